// File: rtl/qcl_pulse_sched_if.sv
// Event/pulse bundle between requesters and the pulse scheduler.
// The master side raises events and the slave side issues the paced pulses.
interface qcl_pulse_sched_if #(
    parameter int els_p = 4
);
    localparam int id_w_lp = $clog2(els_p);

    logic [els_p-1:0]   v_i;
    logic               clr_ovf_i;
    logic               pulse_o;
    logic [id_w_lp-1:0] id_o;
    logic               pending_o;
    logic [els_p-1:0]   ovf_o;

    modport master (
        output v_i, clr_ovf_i,
        input  pulse_o, id_o, pending_o, ovf_o
    );

    modport slave (
        input  v_i, clr_ovf_i,
        output pulse_o, id_o, pending_o, ovf_o
    );
endinterface

// File: rtl/qcl_pulse_sched.sv
// Round-robin pulse scheduler: counts per-requester events and emits paced
// single-cycle pulses, each followed by gap_p idle cycles.
module qcl_pulse_sched #(
    parameter int els_p       = 4,
    parameter int gap_p       = 3,
    parameter int cnt_width_p = 2
) (
    input  logic             clk_i,
    input  logic             reset_i,
    qcl_pulse_sched_if.slave bus
);
    localparam int id_w_lp  = $clog2(els_p);
    localparam int gap_w_lp = $clog2(gap_p + 1);
    localparam logic [cnt_width_p-1:0] cnt_max_lp = '1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] GAP   = 2'd2;

    logic [1:0]             r_state;
    logic [1:0]             w_state_n;
    logic [cnt_width_p-1:0] r_cnt [els_p];
    logic [els_p-1:0]       r_ovf;
    logic                   r_pulse;
    logic [id_w_lp-1:0]     r_id;
    logic [id_w_lp-1:0]     r_last;
    logic [gap_w_lp-1:0]    r_gap;

    logic [els_p-1:0]       w_nz;
    logic [els_p-1:0]       w_dec;
    logic [els_p-1:0]       w_drop;
    logic                   w_any;
    logic                   w_grant;
    logic                   w_found;
    logic                   w_gap_done;
    logic [id_w_lp-1:0]     w_pick;

    always_comb begin
        for (int k = 0; k < els_p; k++) begin
            w_nz[k] = (r_cnt[k] != '0);
        end
    end

    assign w_any      = |w_nz;
    assign w_gap_done = (r_gap == gap_w_lp'(gap_p - 1));

    // Search begins one past the last grant and wraps, so every requester gets a turn.
    always_comb begin
        int                 idx;
        logic [id_w_lp-1:0] sel;
        w_pick  = '0;
        w_found = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int i = 0; i < els_p; i++) begin
            idx = (int'(r_last) + 1 + i) % els_p;
            sel = id_w_lp'(idx);
            if (!w_found && w_nz[sel]) begin
                w_found = 1'b1;
                w_pick  = sel;
            end
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_grant   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_n = ISSUE;
                    w_grant   = 1'b1;
                end
            end
            ISSUE: w_state_n = GAP;
            GAP: begin
                if (w_gap_done) begin
                    if (w_any) begin
                        w_state_n = ISSUE;
                        w_grant   = 1'b1;
                    end else begin
                        w_state_n = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    // A same-cycle grant absorbs an incoming event, so only a lone increment at max is lost.
    always_comb begin
        for (int k = 0; k < els_p; k++) begin
            w_dec[k]  = w_grant && (w_pick == id_w_lp'(k));
            w_drop[k] = bus.v_i[k] && !w_dec[k] && (r_cnt[k] == cnt_max_lp);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_ovf   <= '0;
            r_pulse <= 1'b0;
            r_id    <= '0;
            r_last  <= id_w_lp'(els_p - 1);
            r_gap   <= '0;
            for (int k = 0; k < els_p; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            r_state <= w_state_n;
            r_pulse <= (w_state_n == ISSUE);
            r_gap   <= (r_state == GAP) ? r_gap + gap_w_lp'(1) : '0;
            if (w_grant) begin
                r_id   <= w_pick;
                r_last <= w_pick;
            end
            for (int k = 0; k < els_p; k++) begin
                if (bus.v_i[k] && !w_dec[k]) begin
                    if (r_cnt[k] != cnt_max_lp) begin
                        r_cnt[k] <= r_cnt[k] + cnt_width_p'(1);
                    end
                end else if (!bus.v_i[k] && w_dec[k]) begin
                    r_cnt[k] <= r_cnt[k] - cnt_width_p'(1);
                end
            end
            r_ovf <= (bus.clr_ovf_i ? '0 : r_ovf) | w_drop;
        end
    end

    assign bus.pulse_o   = r_pulse;
    assign bus.id_o      = r_id;
    assign bus.pending_o = w_any;
    assign bus.ovf_o     = r_ovf;
endmodule

// File: tb/tb_qcl_pulse_sched.sv
// Directed bench for qcl_pulse_sched (els_p=4, gap_p=3, cnt_width_p=2):
// per-cycle stimulus tables with hand-computed pulse/id/pending/overflow expectations.
module tb_qcl_pulse_sched;
    logic clk;
    logic reset;

    qcl_pulse_sched_if #(.els_p(4)) bus ();

    qcl_pulse_sched #(
        .els_p       (4),
        .gap_p       (3),
        .cnt_width_p (2)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_err;

    logic [3:0] stim_v   [32];
    logic       stim_clr [32];
    logic       stim_rst [32];
    int         exp_id   [32];
    int         exp_pend [32];
    int         exp_ovf  [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic prep();
        for (int i = 0; i < 32; i++) begin
            stim_v[i]   = '0;
            stim_clr[i] = 1'b0;
            stim_rst[i] = 1'b0;
            exp_id[i]   = -1;
            exp_pend[i] = -1;
            exp_ovf[i]  = -1;
        end
    endtask

    task automatic do_reset(input string tag);
        reset         = 1'b1;
        bus.v_i       = '0;
        bus.clr_ovf_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk({tag, "_rst_pulse"}, {31'b0, bus.pulse_o}, 32'd0);
        chk({tag, "_rst_id"}, {30'b0, bus.id_o}, 32'd0);
        chk({tag, "_rst_pend"}, {31'b0, bus.pending_o}, 32'd0);
        chk({tag, "_rst_ovf"}, {28'b0, bus.ovf_o}, 32'd0);
    endtask

    // Cycle c's inputs are applied and its outputs sampled 1 time unit after edge c.
    task automatic run(input string tag, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            bus.v_i       = stim_v[c];
            bus.clr_ovf_i = stim_clr[c];
            reset         = stim_rst[c];
            chk($sformatf("%s_pulse_c%0d", tag, c), {31'b0, bus.pulse_o},
                (exp_id[c] >= 0) ? 32'd1 : 32'd0);
            if (exp_id[c] >= 0)
                chk($sformatf("%s_id_c%0d", tag, c), {30'b0, bus.id_o}, exp_id[c]);
            if (exp_pend[c] >= 0)
                chk($sformatf("%s_pend_c%0d", tag, c), {31'b0, bus.pending_o}, exp_pend[c]);
            if (exp_ovf[c] >= 0)
                chk($sformatf("%s_ovf_c%0d", tag, c), {28'b0, bus.ovf_o}, exp_ovf[c]);
            @(posedge clk);
            #1;
        end
        bus.v_i       = '0;
        bus.clr_ovf_i = 1'b0;
        reset         = 1'b0;
    endtask

    initial begin
        n_chk         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.v_i       = '0;
        bus.clr_ovf_i = 1'b0;

        // Single event: pulse in cycle 2 only, id 0, pending clears at cycle 2.
        do_reset("single");
        prep();
        stim_v[0] = 4'b0001;
        exp_id[2] = 0;
        exp_pend[0] = 0;
        exp_pend[1] = 1;
        for (int i = 2; i < 12; i++) exp_pend[i] = 0;
        run("single", 12);

        // All four requesters at once: pulses every 4 cycles in index order.
        do_reset("all4");
        prep();
        stim_v[0]  = 4'b1111;
        exp_id[2]  = 0;
        exp_id[6]  = 1;
        exp_id[10] = 2;
        exp_id[14] = 3;
        exp_pend[13] = 1;
        for (int i = 14; i < 20; i++) exp_pend[i] = 0;
        exp_ovf[19] = 0;
        run("all4", 20);

        // Requester 2 floods for 5 cycles while requester 0 is served: 3 counted, 2 dropped.
        do_reset("ovf");
        prep();
        stim_v[0] = 4'b0101;
        for (int i = 1; i < 5; i++) stim_v[i] = 4'b0100;
        stim_clr[20] = 1'b1;
        exp_id[2]  = 0;
        exp_id[6]  = 2;
        exp_id[10] = 2;
        exp_id[14] = 2;
        exp_ovf[3] = 0;
        for (int i = 4; i < 21; i++) exp_ovf[i] = 4'b0100;
        for (int i = 21; i < 24; i++) exp_ovf[i] = 0;
        exp_pend[13] = 1;
        exp_pend[14] = 0;
        run("ovf", 24);

        // Event on the grant edge of requester 1 (count 1): net count stays 1, one more pulse.
        do_reset("netzero");
        prep();
        stim_v[0] = 4'b0010;
        stim_v[1] = 4'b0010;
        exp_id[2] = 1;
        exp_id[6] = 1;
        exp_pend[2] = 1;
        for (int i = 6; i < 14; i++) exp_pend[i] = 0;
        run("netzero", 14);

        // Reset during GAP with all counts saturated discards everything.
        do_reset("midrst");
        prep();
        for (int i = 0; i < 4; i++) stim_v[i] = 4'b1111;
        stim_rst[4] = 1'b1;
        exp_id[2]   = 0;
        exp_pend[4] = 1;
        for (int i = 5; i < 27; i++) exp_pend[i] = 0;
        exp_ovf[5] = 0;
        run("midrst", 27);

        // Requester 0 always busy, requester 3 once: served on the very next turn.
        do_reset("rr");
        prep();
        stim_v[0] = 4'b1001;
        for (int i = 1; i < 20; i++) stim_v[i] = 4'b0001;
        exp_id[2]  = 0;
        exp_id[6]  = 3;
        exp_id[10] = 0;
        exp_id[14] = 0;
        exp_id[18] = 0;
        run("rr", 20);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
